// File: rtl/kp_window_ctrl.sv
// 3x3 window sequencer: turns a raster pixel stream into three 3-pixel row buses
// (oldest line on r0, current line on r2) for the downstream kp_* kernel.
module kp_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  input  logic                    i_sof,
  output logic [3*DATA_WIDTH-1:0] o_r0_data,
  output logic [3*DATA_WIDTH-1:0] o_r1_data,
  output logic [3*DATA_WIDTH-1:0] o_r2_data,
  output logic                    o_valid,
  output logic [1:0]              o_state
);

  // Handshake: a pixel is accepted on every rising edge where i_valid=1 (no
  // backpressure); o_valid is a one-cycle pulse, and the row buses hold otherwise.

  localparam int DW = DATA_WIDTH;
  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   col, col_next, col_eff;
  logic            eol;
  logic            win_done;

  logic [DW-1:0]   lb0 [LINE_WIDTH];
  logic [DW-1:0]   lb1 [LINE_WIDTH];
  logic [DW-1:0]   lb0_q, lb1_q, pix_q;
  logic            pix_v1, win_v1;

  logic [2*DW-1:0] sr0, sr1, sr2;
  logic [3*DW-1:0] sr0_new, sr1_new, sr2_new;

  // A start-of-frame pixel always lands in column 0, whatever col held.
  assign col_eff  = i_sof ? '0 : col;
  assign eol      = i_valid && !i_sof && (col == COL_LAST);
  assign win_done = i_valid && !i_sof && (state == RUN) && (col >= CW'(2));

  always_comb begin
    state_next = state;
    col_next   = col;
    if (i_valid) begin
      if (i_sof) begin
        state_next = FILL0;
        col_next   = CW'(1);
      end else if (eol) begin
        col_next = '0;
        case (state)
          FILL0:   state_next = FILL1;
          FILL1:   state_next = RUN;
          default: state_next = RUN;
        endcase
      end else begin
        col_next = col + 1'b1;
      end
    end
  end

  // Line buffers are RAM-like: read-before-write at the same column, no reset.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb0_q         <= lb0[col_eff];
      lb1_q         <= lb1[col_eff];
      pix_q         <= i_data;
      lb0[col_eff]  <= lb1[col_eff];
      lb1[col_eff]  <= i_data;
    end
  end

  assign sr0_new = {sr0, lb0_q};
  assign sr1_new = {sr1, lb1_q};
  assign sr2_new = {sr2, pix_q};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= FILL0;
      col       <= '0;
      pix_v1    <= 1'b0;
      win_v1    <= 1'b0;
      sr0       <= '0;
      sr1       <= '0;
      sr2       <= '0;
      o_valid   <= 1'b0;
      o_r0_data <= '0;
      o_r1_data <= '0;
      o_r2_data <= '0;
    end else begin
      state   <= state_next;
      col     <= col_next;
      pix_v1  <= i_valid;
      win_v1  <= win_done;
      o_valid <= win_v1;
      // Shift registers run one stage behind the accepted pixel, on the read data.
      if (pix_v1) begin
        sr0 <= sr0_new[2*DW-1:0];
        sr1 <= sr1_new[2*DW-1:0];
        sr2 <= sr2_new[2*DW-1:0];
      end
      if (win_v1) begin
        o_r0_data <= sr0_new;
        o_r1_data <= sr1_new;
        o_r2_data <= sr2_new;
      end
    end
  end

  assign o_state = state;

endmodule
